ps2_kbd_rx: RTL

PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

---
 rtl/ps2_kbd_rx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver. Synchronizes the raw PS/2 clock and
// data lines, deserializes 11-bit frames (start, 8 data LSB first, odd parity,
// stop), folds E0/F0 prefixes into the decoded scan code and tracks the space
// key to produce a single "flap" pulse per fresh press.
module ps2_kbd_rx #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       RSTN,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,   // break flag: code was preceded by F0
    output logic       code_valid,
    output logic       frame_err,
    output logic       space_down,
    output logic       flap
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    PFX_EXT = 8'hE0;
    localparam logic [7:0]    PFX_BRK = 8'hF0;
    localparam logic [7:0]    SPACE   = 8'h29;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic          ps2c_s1, ps2c_s2, ps2c_s3;
    logic          ps2d_s1, ps2d_s2;
    logic          fall;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          ext_pending, brk_pending;

    // FSM strobes
    logic bit_clr, shift_en, parity_en, frame_done, frame_abort, timeout;
    logic frame_good, frame_bad;

    // Two-flop synchronizers plus a third clock flop for edge detection.
    // NOTE: these flops reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            ps2c_s1 <= 1'b1;
            ps2c_s2 <= 1'b1;
            ps2c_s3 <= 1'b1;
            ps2d_s1 <= 1'b1;
            ps2d_s2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, forming a true shift chain.
            ps2c_s1 <= PS2C;
            ps2c_s2 <= ps2c_s1;
            ps2c_s3 <= ps2c_s2;
            ps2d_s1 <= PS2D;
            ps2d_s2 <= ps2d_s1;
        end
    end

    assign fall    = ps2c_s3 & ~ps2c_s2;
    assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic and datapath strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        bit_clr     = 1'b0;
        shift_en    = 1'b0;
        parity_en   = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        if (timeout) begin
            state_next  = IDLE;
            frame_abort = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !ps2d_s2) begin
                        state_next = DATA;
                        bit_clr    = 1'b1;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7) state_next = PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        parity_en  = 1'b1;
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (fall) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame is accepted only with stop bit 1 and odd parity over data + parity.
    assign frame_good = frame_done && ps2d_s2 && (^{shift_reg, parity_bit});
    assign frame_bad  = (frame_done && !frame_good) || frame_abort;

    // Bit counter, LSB-first shift register and parity latch.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else begin
            if (bit_clr) begin
                bit_cnt   <= 3'd0;
                shift_reg <= 8'h00;
            end else if (shift_en) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= {ps2d_s2, shift_reg[7:1]};
            end
            if (parity_en) parity_bit <= ps2d_s2;
        end
    end

    // Inactivity counter: restarts on each PS/2 clock edge, idles at 0 in IDLE.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            to_cnt <= '0;
        end else if (fall || state == IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Byte processing: prefix tracking, decoded outputs and space-key state.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            code        <= 8'h00;
            extended    <= 1'b0;
            released    <= 1'b0;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
            space_down  <= 1'b0;
            flap        <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            flap       <= 1'b0;
            if (frame_bad) begin
                frame_err   <= 1'b1;
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
            end else if (frame_good) begin
                if (shift_reg == PFX_EXT) begin
                    ext_pending <= 1'b1;
                end else if (shift_reg == PFX_BRK) begin
                    brk_pending <= 1'b1;
                end else begin
                    code        <= shift_reg;
                    extended    <= ext_pending;
                    released    <= brk_pending;
                    code_valid  <= 1'b1;
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                    // Typematic repeats of a held space key must not re-trigger flap.
                    if (shift_reg == SPACE && !ext_pending) begin
                        if (!brk_pending) begin
                            space_down <= 1'b1;
                            flap       <= ~space_down;
                        end else begin
                            space_down <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
